tcp_rx_port_arbiter: RTL and testbench
======================================

# tcp_rx_port_arbiter

Packet-granularity round-robin arbiter that shares the single TCP receive parser among `NUM_PORTS` upstream word streams. It sits between the per-port IP de-encapsulation outputs and the parser's `tcp_data_in`/`tcp_data_valid` input. The parser has no backpressure and treats any valid-low cycle as end-of-segment. This block therefore guarantees contiguous valid words per segment and at least one idle cycle between segments. It also polices gaps and over-length segments.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesting streams (2..8).
- `DATA_W`, 32: word width; must match the parser input.
- `MAX_WORDS`, 375: maximum words per segment (1500 B / 4).
- `PORT_W`, `$clog2(NUM_PORTS)`: port index width (derived).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  `NUM_PORTS*DATA_W`  port p word in bits `[p*DATA_W +: DATA_W]`.
- `in_valid`  in  `NUM_PORTS`  per-port word valid.
- `in_last`  in  `NUM_PORTS`  per-port last word of segment.
- `in_ready`  out  `NUM_PORTS`  per-port accept; one-hot or zero.
- `out_data`  out  `DATA_W`  word to parser `tcp_data_in`.
- `out_valid`  out  1  to parser `tcp_data_valid`.
- `out_last`  out  1  last word of forwarded segment.
- `out_port`  out  `PORT_W`  source port of current word.
- `err_gap`  out  1  one-cycle pulse: granted port dropped valid mid-segment.
- `err_len`  out  1  one-cycle pulse: segment truncated at `MAX_WORDS`.
- `err_port`  out  `PORT_W`  port associated with the error pulse.
- `busy`  out  1  state is not IDLE.

## Operation
- Clock `clk`; `reset` is synchronous and active-high. All outputs reset to 0. State resets to IDLE, and the RR pointer resets to `NUM_PORTS-1`, so port 0 has first priority.
- A word is accepted when `in_valid[g] & in_ready[g]`. `in_ready[g]` is 1 only in FWD or DRAIN, and only for the granted port `g`.
- **IDLE**
  - If any `in_valid` is set, grant the first requester after the RR pointer, wrapping.
  - Register `g` and set the pointer to `g`.
  - Clear the word counter and go to FWD.
  - No word is accepted in IDLE.
- **FWD**
  - On an accepted word: register `out_data`/`out_valid`/`out_port`/`out_last=in_last[g]` and increment the counter.
  - If `in_last[g]` is set, go to IDLE.
  - If the counter reaches `MAX_WORDS` without `in_last`:
    - force `out_last=1`;
    - pulse `err_len`;
    - go to DRAIN.
  - If `in_valid[g]=0`:
    - `out_valid=0` next cycle;
    - pulse `err_gap`;
    - go to DRAIN. The already-forwarded words are not retroactively terminated, because the parser ends the segment on the valid drop.
- **DRAIN**
  - `in_ready[g]=1`; accepted words are discarded and `out_valid` stays 0.
  - On an accepted word with `in_last[g]`, go to IDLE. Valid-low cycles are tolerated.
- `err_port` carries `g` in the cycle an error pulse is asserted.
- If `in_valid[g]` and `in_last[g]` arrive on a word that also hits `MAX_WORDS`, treat it as a normal last: no `err_len`, go to IDLE.
- Width rule: the counter is `$clog2(MAX_WORDS+1)` bits and saturates at `MAX_WORDS`.

## Timing
- Grant latency: a request first seen in IDLE at cycle t is accepted at t+1 at the earliest. The word appears on `out_*` at t+2.
- Pipeline latency: a word accepted at cycle c is on `out_*` at c+1, registered.
- Inter-segment spacing: last word accepted at c, so FWD→IDLE at c+1. The next grant's first word is accepted at c+2 and output at c+3. `out_valid` is therefore low at c+2, guaranteeing at least one idle cycle at the parser.
- Throughput: one word per cycle within a segment; per-segment overhead is 1 cycle.
- Error pulses coincide with the first cycle where `out_valid` reflects the error: the c+1 of the gap cycle, or of the truncating word.
- Reset mid-segment: the next cycle shows `out_valid=0` and all `in_ready=0`. The partially sent segment is abandoned with no error pulse.

## Structure
- Package `tcp_rx_pkg` holds:
  - `arb_state_t` enum {IDLE, FWD, DRAIN};
  - `TCP_DATA_W=32`;
  - `TCP_MAX_WORDS=375`.
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index.
  - Reusable by other shared-resource blocks.
- Top level holds the FSM, counter, output register and error logic.

## Test plan
- **Single segment:** port 2 sends `0x11110001`, `0x11110002`, `0x11110003` (last on the third) → three contiguous `out_valid` cycles with `out_port=2` and `out_last` on the third; no errors.
- **Simultaneous requests:** after reset, ports 0–3 each request with 2-word segments → served in order 0,1,2,3, with exactly one `out_valid=0` cycle between segments.
- **Fairness:** ports 0 and 3 request continuously → grants alternate 0,3,0,3; port 0 is never granted twice in a row.
- **Gap:** port 1 sends 2 words, valid low for 1 cycle, then 2 words with last → 2 words out with `out_last=0`; `err_gap=1` with `err_port=1`; remaining words are accepted but not output; then IDLE.
- **Over-length:** `MAX_WORDS=4`, port 0 sends 6 words with last on the 6th → 4 words out, `out_last=1` on the 4th; `err_len=1` and `err_port=0`; words 5–6 are discarded.
- **Reset mid-segment:** reset asserted on the 3rd word of port 2 → `out_valid=0` and `in_ready=0` the next cycle; after release, port 0 wins the first grant.

Source files
------------

// File: rtl/tcp_rx_pkg.sv
// Shared types and defaults for the TCP receive path.
//   arb_state_t   : arbiter FSM states (IDLE, FWD, DRAIN)
//   TCP_DATA_W    : parser input word width
//   TCP_MAX_WORDS : longest legal segment in words (1500 B / 4 B)
package tcp_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int TCP_DATA_W    = 32;
  localparam int TCP_MAX_WORDS = 375;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick. Searches the request vector starting at
// the position just after ptr, wrapping, and returns the first requester.
//   req   in  N  request vector
//   ptr   in  W  last winner; it gets the lowest priority
//   grant out N  one-hot grant, zero when there are no requests
//   idx   out W  index of the granted requester, 0 when there are none
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);

  logic [W-1:0] cand;
  logic         found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = W'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/tcp_rx_port_arbiter.sv
// Packet-granularity round-robin arbiter feeding the single TCP parser.
// Segments leave as contiguous valid words with at least one idle cycle
// between them; gaps and over-length segments are cut and flagged.
//   clk, reset  clock; synchronous active-high reset
//   in_data     NUM_PORTS*DATA_W  per-port words, port p at [p*DATA_W +: DATA_W]
//   in_valid    per-port word valid
//   in_last     per-port end of segment
//   in_ready    per-port accept, only the granted port in FWD/DRAIN
//   out_data / out_valid / out_last / out_port  registered word to the parser
//   err_gap     pulse: granted port dropped valid mid-segment
//   err_len     pulse: segment cut at MAX_WORDS
//   err_port    port tied to the error pulse
//   busy        FSM is not IDLE
//
// state | meaning
// IDLE  | no grant; pick the next requester after the RR pointer
// FWD   | forwarding words of granted port g, one per cycle
// DRAIN | discarding the rest of g's segment after a gap or truncation
module tcp_rx_port_arbiter
  import tcp_rx_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = TCP_DATA_W,
  parameter int MAX_WORDS = TCP_MAX_WORDS,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS-1:0]        in_last,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [PORT_W-1:0]           out_port,
  output logic                        err_gap,
  output logic                        err_len,
  output logic [PORT_W-1:0]           err_port,
  output logic                        busy
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  arb_state_t        state, state_n;
  logic [PORT_W-1:0] g, g_n, ptr, ptr_n;
  logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
  logic [DATA_W-1:0] data_n;
  logic              valid_n, last_n, gap_n, len_n;
  logic [PORT_W-1:0] port_n, eport_n;

  logic [NUM_PORTS-1:0] pick_oh;
  logic [PORT_W-1:0]    pick_idx;
  logic [DATA_W-1:0]    words [NUM_PORTS];
  logic                 g_valid, g_last;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign words[i] = in_data[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_PORTS), .W(PORT_W)) u_rr (
    .req   (in_valid),
    .ptr   (ptr),
    .grant (pick_oh),
    .idx   (pick_idx)
  );

  assign g_valid  = in_valid[g];
  assign g_last   = in_last[g];
  assign busy     = (state != IDLE);
  assign in_ready = (state == FWD || state == DRAIN) ?
                    ({{(NUM_PORTS-1){1'b0}}, 1'b1} << g) : '0;

  // Saturating so the count can never wrap past MAX_WORDS.
  assign cnt_inc = (cnt == CNT_W'(MAX_WORDS)) ? cnt : cnt + 1'b1;

  always_comb begin
    state_n = state;
    g_n     = g;
    ptr_n   = ptr;
    cnt_n   = cnt;
    data_n  = out_data;
    valid_n = 1'b0;
    last_n  = 1'b0;
    port_n  = out_port;
    gap_n   = 1'b0;
    len_n   = 1'b0;
    eport_n = err_port;
    case (state)
      IDLE: begin
        if (|pick_oh) begin
          g_n     = pick_idx;
          ptr_n   = pick_idx;
          cnt_n   = '0;
          state_n = FWD;
        end
      end
      FWD: begin
        if (g_valid) begin
          data_n  = words[g];
          valid_n = 1'b1;
          port_n  = g;
          cnt_n   = cnt_inc;
          // A genuine last on the MAX_WORDS-th word wins over truncation.
          if (g_last) begin
            last_n  = 1'b1;
            state_n = IDLE;
          end else if (cnt_inc == CNT_W'(MAX_WORDS)) begin
            last_n  = 1'b1;
            len_n   = 1'b1;
            eport_n = g;
            state_n = DRAIN;
          end
        end else begin
          // The parser already ends the segment on the valid drop.
          gap_n   = 1'b1;
          eport_n = g;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (g_valid && g_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      g         <= '0;
      ptr       <= PORT_W'(NUM_PORTS - 1);
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_port  <= '0;
      err_gap   <= 1'b0;
      err_len   <= 1'b0;
      err_port  <= '0;
    end else begin
      state     <= state_n;
      g         <= g_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      out_data  <= data_n;
      out_valid <= valid_n;
      out_last  <= last_n;
      out_port  <= port_n;
      err_gap   <= gap_n;
      err_len   <= len_n;
      err_port  <= eport_n;
    end
  end

endmodule

// File: tb/tb_tcp_rx_port_arbiter.sv
// Testbench for tcp_rx_port_arbiter: directed scenarios plus random
// segment mixes, scored against a segment-level reference model.
module tb_tcp_rx_port_arbiter;
  localparam int NP = 4, DW = 32, MAXW = 4, PW = 2;
  localparam int MAXSEG = 6, MAXLEN = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP-1:0] in_valid = '0, in_last = '0, in_ready;
  logic [DW-1:0] out_data;
  logic out_valid, out_last, err_gap, err_len, busy;
  logic [PW-1:0] out_port, err_port;

  always #5 clk = ~clk;

  tcp_rx_port_arbiter #(.NUM_PORTS(NP), .DATA_W(DW), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_port(out_port),
    .err_gap(err_gap), .err_len(err_len), .err_port(err_port), .busy(busy)
  );

  int total = 0, bad = 0;

  // Source segments per port: length, gap position (0 = none), words.
  int nseg [NP];
  int slen [NP][MAXSEG];
  int sgap [NP][MAXSEG];
  logic [DW-1:0] wd [NP][MAXSEG][MAXLEN];
  int sh [NP], wi [NP];
  bit spent [NP];
  logic [NP-1:0] acc_prev;

  logic [PW+DW:0] exp_w [$];   // {port, last, data}
  logic [PW:0]    exp_e [$];   // {is_len, port}
  bit prev_ov, prev_ol;
  int cyc, first_out, last_out;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = '0; in_last = '0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {out_data, out_valid, out_last, out_port, err_gap,
                            err_len, err_port, busy, in_ready}, '0);
    reset = 1'b0;
  endtask

  task automatic clear_sources();
    for (int p = 0; p < NP; p++) begin
      nseg[p] = 0; sh[p] = 0; wi[p] = 0; spent[p] = 0;
    end
    exp_w.delete(); exp_e.delete();
    acc_prev = '0;
  endtask

  task automatic add_seg(input int p, input int len, input int gap, input logic [DW-1:0] base);
    int s;
    s = nseg[p];
    slen[p][s] = len; sgap[p][s] = gap;
    for (int w = 0; w < len; w++)
      wd[p][s][w] = (base != 0) ? base + DW'(w + 1) : DW'($urandom);
    nseg[p]++;
  endtask

  // Segment-level model: the next pending port after the last winner is
  // served; its segment is forwarded up to the first gap or MAX_WORDS.
  task automatic build_expected();
    int rem [NP];
    int nxt [NP];
    int ptr, c, s, L, k, n;
    bit trunc, gap_err, left;
    ptr = NP - 1;
    for (int p = 0; p < NP; p++) begin rem[p] = nseg[p]; nxt[p] = 0; end
    left = 1;
    while (left) begin
      left = 0;
      for (int p = 0; p < NP; p++) if (rem[p] > 0) left = 1;
      if (left) begin
        c = -1;
        for (int i = 1; i <= NP; i++)
          if (c < 0 && rem[(ptr + i) % NP] > 0) c = (ptr + i) % NP;
        ptr = c; s = nxt[c]; nxt[c]++; rem[c]--;
        L = slen[c][s]; k = sgap[c][s];
        trunc   = (L > MAXW) && (k == 0 || k >= MAXW);
        gap_err = !trunc && (k != 0);
        n = trunc ? MAXW : (gap_err ? k : L);
        for (int w = 0; w < n; w++)
          exp_w.push_back({PW'(c), (w == n - 1) && !gap_err, wd[c][s][w]});
        if (trunc)   exp_e.push_back({1'b1, PW'(c)});
        if (gap_err) exp_e.push_back({1'b0, PW'(c)});
      end
    end
  endtask

  task automatic sample();
    logic [PW:0] e;
    check("ready_onehot0", $onehot0(in_ready), 1);
    if (out_valid) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (exp_w.size() == 0) check("extra_word", out_valid, 0);
      else check("word", {out_port, out_last, out_data}, exp_w.pop_front());
    end
    if (err_gap || err_len) begin
      if (exp_e.size() == 0) check("extra_err", {err_gap, err_len}, 0);
      else begin
        e = exp_e.pop_front();
        check("err", {err_gap, err_len, err_port}, {~e[PW], e[PW], e[PW-1:0]});
      end
      if (err_gap) check("gap_no_valid", out_valid, 0);
      if (err_len) check("len_forces_last", {out_valid, out_last}, 2'b11);
    end
    if (prev_ov && prev_ol) check("idle_between", out_valid, 0);
    if (prev_ov && !prev_ol && !out_valid) check("gap_flagged", err_gap, 1);
    prev_ov = out_valid; prev_ol = out_last;
  endtask

  task automatic advance();
    for (int p = 0; p < NP; p++)
      if (acc_prev[p]) begin
        if (wi[p] == slen[p][sh[p]] - 1) begin
          sh[p]++; wi[p] = 0; spent[p] = 0;
        end else wi[p]++;
      end
  endtask

  task automatic drive();
    int s, w;
    for (int p = 0; p < NP; p++) begin
      in_valid[p] = 1'b0; in_last[p] = 1'b0;
      if (sh[p] < nseg[p]) begin
        s = sh[p]; w = wi[p];
        if (w > 0 && w == sgap[p][s] && !spent[p]) spent[p] = 1;
        else begin
          in_valid[p] = 1'b1;
          in_last[p]  = (w == slen[p][s] - 1);
          in_data[p*DW +: DW] = wd[p][s][w];
        end
      end
    end
  endtask

  task automatic run_scenario(input int budget);
    bit done;
    build_expected();
    cyc = 0; first_out = -1; last_out = -1; prev_ov = 0; prev_ol = 0;
    acc_prev = '0; done = 0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      sample(); advance(); drive();
      acc_prev = in_valid & in_ready;
      cyc++;
      done = (exp_w.size() == 0) && (exp_e.size() == 0);
      for (int p = 0; p < NP; p++) if (sh[p] < nseg[p]) done = 0;
    end
    check("scenario_complete", done, 1);
    repeat (3) begin
      @(negedge clk);
      sample(); drive();
    end
  endtask

  initial begin
    // single segment on port 2
    do_reset(); clear_sources();
    add_seg(2, 3, 0, 32'h1111_0000);
    run_scenario(50);
    check("single_latency", first_out, 2);
    check("single_span", last_out - first_out, 2);

    // simultaneous requests: 0,1,2,3 with one idle cycle between segments
    do_reset(); clear_sources();
    for (int p = 0; p < NP; p++) add_seg(p, 2, 0, 32'hA000_0000 + DW'(p << 8));
    run_scenario(80);
    check("simul_latency", first_out, 2);
    check("simul_span", last_out - first_out, 10);

    // fairness: ports 0 and 3 alternate
    do_reset(); clear_sources();
    for (int s = 0; s < 3; s++) begin add_seg(0, 2, 0, 0); add_seg(3, 1, 0, 0); end
    run_scenario(100);
    check("fair_span", last_out - first_out, 13);

    // gap on port 1 after two words
    do_reset(); clear_sources();
    add_seg(1, 4, 2, 32'h5555_0000);
    run_scenario(50);
    check("gap_back_idle", busy, 0);

    // over-length on port 0, truncated at MAX_WORDS
    do_reset(); clear_sources();
    add_seg(0, 6, 0, 32'h6666_0000);
    run_scenario(50);
    check("len_back_idle", busy, 0);

    // last exactly at MAX_WORDS is a normal end
    do_reset(); clear_sources();
    add_seg(3, 4, 0, 32'h7777_0000);
    run_scenario(50);

    // reset on the third word of port 2
    do_reset(); clear_sources();
    @(negedge clk);
    in_valid = 4'b0100; in_last = '0; in_data[2*DW +: DW] = 32'h2222_0001;
    @(negedge clk);
    @(negedge clk);
    check("rm_ready_mid", in_ready, 4'b0100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rm_out_valid", out_valid, 0);
    check("rm_ready", in_ready, 0);
    check("rm_no_err", {err_gap, err_len}, 0);
    reset = 1'b0;
    in_valid = 4'b0101; in_data[0 +: DW] = 32'h0000_0AAA;
    @(negedge clk);
    check("rm_first_grant", in_ready, 4'b0001);
    @(negedge clk);
    check("rm_first_word", {out_valid, out_port, out_data}, {1'b1, 2'd0, 32'h0000_0AAA});
    in_valid = '0;

    // random mixes
    for (int r = 0; r < 30; r++) begin
      int n, len, gap;
      do_reset(); clear_sources();
      for (int p = 0; p < NP; p++) begin
        n = $urandom_range(0, 3);
        for (int s = 0; s < n; s++) begin
          len = $urandom_range(1, MAXLEN);
          gap = (len >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : 0;
          add_seg(p, len, gap, 0);
        end
      end
      run_scenario(400);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
